// File: rtl/hazard_pkg.sv
// Shared types and limits for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_MEM_WAIT = 2'd1,
        HZ_TIMEOUT  = 2'd2
    } hz_state_e;

    localparam logic [3:0] REG_PC      = 4'hF;
    localparam logic [7:0] WAIT_LIMIT  = 8'd255;
    localparam int         STALL_CNT_W = 16;

endpackage

// File: rtl/pipe_hazard_ctrl_src_match.sv
// Flags a used ID source operand that the EX instruction is about to write.
// Writes to the PC register are never forwarded, so they never match.
module src_match
    import hazard_pkg::*;
(
    input  logic [3:0] src,
    input  logic       use_src,
    input  logic [3:0] ex_reg_dst,
    output logic       hit
);

    assign hit = use_src && (src == ex_reg_dst) && (ex_reg_dst != REG_PC);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller: load-use interlock, branch flush and data-memory wait
// with a timeout that parks the pipeline until reset.
//
//  state     | meaning
//  RUN       | normal issue; load-use stall and branch flush evaluated here
//  MEM_WAIT  | data memory busy; whole pipeline frozen, wait_cnt running
//  TIMEOUT   | memory never answered; pipeline frozen until reset
module pipe_hazard_ctrl
    import hazard_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3:0]             id_rn,
    input  logic [3:0]             id_rm,
    input  logic [3:0]             id_rs,
    input  logic                   id_use_rn,
    input  logic                   id_use_rm,
    input  logic                   id_use_rs,
    input  logic                   id_branch_taken,
    input  logic [3:0]             ex_reg_dst,
    input  logic                   ex_load,
    input  logic                   mem_req,
    input  logic                   mem_ready,
    output logic                   pc_we,
    output logic                   if_id_we,
    output logic                   id_ex_we,
    output logic                   ex_mem_we,
    output logic                   if_id_flush,
    output logic                   id_ex_bubble,
    output logic [1:0]             state,
    output logic [STALL_CNT_W-1:0] stall_count,
    output logic                   mem_timeout
);

    localparam logic [1:0] RUN      = HZ_RUN;
    localparam logic [1:0] MEM_WAIT = HZ_MEM_WAIT;
    localparam logic [1:0] TIMEOUT  = HZ_TIMEOUT;

    logic       hit_rn, hit_rm, hit_rs;
    logic       load_use;
    logic       mem_stall;
    logic [7:0] wait_cnt;

    src_match u_match_rn (.src(id_rn), .use_src(id_use_rn), .ex_reg_dst(ex_reg_dst), .hit(hit_rn));
    src_match u_match_rm (.src(id_rm), .use_src(id_use_rm), .ex_reg_dst(ex_reg_dst), .hit(hit_rm));
    src_match u_match_rs (.src(id_rs), .use_src(id_use_rs), .ex_reg_dst(ex_reg_dst), .hit(hit_rs));

    assign load_use  = ex_load && (hit_rn || hit_rm || hit_rs);
    assign mem_stall = mem_req && !mem_ready;

    always_comb begin
        pc_we        = 1'b0;
        if_id_we     = 1'b0;
        id_ex_we     = 1'b0;
        ex_mem_we    = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        if (!reset) begin
            id_ex_bubble = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (mem_stall) begin
                        pc_we = 1'b0;
                    end else if (load_use) begin
                        // Hold PC and IF/ID, let EX drain, inject a bubble behind it.
                        id_ex_we     = 1'b1;
                        ex_mem_we    = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else begin
                        pc_we       = 1'b1;
                        if_id_we    = 1'b1;
                        id_ex_we    = 1'b1;
                        ex_mem_we   = 1'b1;
                        if_id_flush = id_branch_taken;
                    end
                end
                MEM_WAIT: begin
                    pc_we     = mem_ready;
                    if_id_we  = mem_ready;
                    id_ex_we  = mem_ready;
                    ex_mem_we = mem_ready;
                end
                default: pc_we = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= RUN;
            wait_cnt    <= 8'd0;
            stall_count <= '0;
            mem_timeout <= 1'b0;
        end else begin
            if (!pc_we && stall_count != {STALL_CNT_W{1'b1}})
                stall_count <= stall_count + 1'b1;
            case (state)
                RUN: begin
                    wait_cnt <= 8'd0;
                    if (mem_stall)
                        state <= MEM_WAIT;
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        state    <= RUN;
                        wait_cnt <= 8'd0;
                    end else if (wait_cnt == WAIT_LIMIT) begin
                        state       <= TIMEOUT;
                        mem_timeout <= 1'b1;
                        wait_cnt    <= 8'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: state <= TIMEOUT;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed and randomised bench for pipe_hazard_ctrl with a reference model and
// an expected-output queue checked every cycle.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  id_rn, id_rm, id_rs, ex_reg_dst;
    logic        id_use_rn, id_use_rm, id_use_rs;
    logic        id_branch_taken, ex_load, mem_req, mem_ready;
    logic        pc_we, if_id_we, id_ex_we, ex_mem_we, if_id_flush, id_ex_bubble;
    logic [1:0]  state;
    logic [15:0] stall_count;
    logic        mem_timeout;

    pipe_hazard_ctrl dut (
        .clk(clk), .reset(reset),
        .id_rn(id_rn), .id_rm(id_rm), .id_rs(id_rs),
        .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_use_rs(id_use_rs),
        .id_branch_taken(id_branch_taken), .ex_reg_dst(ex_reg_dst), .ex_load(ex_load),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we), .ex_mem_we(ex_mem_we),
        .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
        .state(state), .stall_count(stall_count), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        pc_we, if_id_we, id_ex_we, ex_mem_we, if_id_flush, id_ex_bubble;
        logic [1:0]  state;
        logic [15:0] stall_count;
        logic        mem_timeout;
    } obs_t;

    obs_t        exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    logic [1:0]  m_state;
    logic [7:0]  m_wait;
    logic [15:0] m_stall;
    logic        m_to;

    function automatic obs_t predict();
        obs_t e;
        logic lu;
        lu = ex_load && ex_reg_dst != 4'hF &&
             ((id_use_rn && id_rn == ex_reg_dst) ||
              (id_use_rm && id_rm == ex_reg_dst) ||
              (id_use_rs && id_rs == ex_reg_dst));
        e = '0;
        e.state       = m_state;
        e.stall_count = m_stall;
        e.mem_timeout = m_to;
        if (!reset) begin
            e.id_ex_bubble = 1'b1;
        end else if (m_state == 2'd0) begin
            if (mem_req && !mem_ready) begin
                e.pc_we = 1'b0;
            end else if (lu) begin
                {e.id_ex_we, e.ex_mem_we, e.id_ex_bubble} = 3'b111;
            end else begin
                {e.pc_we, e.if_id_we, e.id_ex_we, e.ex_mem_we} = 4'b1111;
                e.if_id_flush = id_branch_taken;
            end
        end else if (m_state == 2'd1) begin
            {e.pc_we, e.if_id_we, e.id_ex_we, e.ex_mem_we} = {4{mem_ready}};
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs are already driven (just after a negedge); compare, then advance one clock.
    task automatic step(input string tag);
        obs_t e, got, o;
        #1;
        e = predict();
        exp_q.push_back(e);
        o = {pc_we, if_id_we, id_ex_we, ex_mem_we, if_id_flush, id_ex_bubble,
             state, stall_count, mem_timeout};
        got = exp_q.pop_front();
        check(tag, 32'(o), 32'(got));
        @(posedge clk);
        if (!reset) begin
            m_state = 2'd0; m_wait = 8'd0; m_stall = 16'd0; m_to = 1'b0;
        end else begin
            if (!e.pc_we && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
            case (m_state)
                2'd0: if (mem_req && !mem_ready) begin m_state = 2'd1; m_wait = 8'd0; end
                2'd1: begin
                    if (mem_ready) begin
                        m_state = 2'd0; m_wait = 8'd0;
                    end else if (m_wait == 8'd255) begin
                        m_state = 2'd2; m_to = 1'b1;
                    end else begin
                        m_wait = m_wait + 8'd1;
                    end
                end
                default: m_state = 2'd2;
            endcase
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        reset = 1'b1;
        {id_rn, id_rm, id_rs, ex_reg_dst} = '0;
        {id_use_rn, id_use_rm, id_use_rs, id_branch_taken, ex_load, mem_req} = '0;
        mem_ready = 1'b0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        m_state = 2'd0; m_wait = 8'd0; m_stall = 16'd0; m_to = 1'b0;
        @(posedge clk);
        @(negedge clk);

        step("reset_hold0");
        step("reset_hold1");
        reset = 1'b1;
        step("run_idle0");
        step("run_idle1");

        // load-use on rn
        ex_load = 1'b1; ex_reg_dst = 4'd3; id_rn = 4'd3; id_use_rn = 1'b1;
        #1;
        check("lu_pc_we", 32'(pc_we), 32'd0);
        check("lu_bubble", 32'(id_ex_bubble), 32'd1);
        step("lu_rn");
        ex_load = 1'b0;
        step("lu_released");
        check("lu_stall_count", 32'(stall_count), 32'd1);

        // PC destination never stalls
        ex_load = 1'b1; ex_reg_dst = 4'hF; id_rn = 4'hF;
        #1;
        check("pc_dst_pc_we", 32'(pc_we), 32'd1);
        step("pc_dst");
        ex_reg_dst = 4'd5; id_rn = 4'd0; id_rm = 4'd5; id_use_rm = 1'b1;
        step("lu_rm");
        id_use_rm = 1'b0;
        step("rm_unused");
        id_rs = 4'd5; id_use_rs = 1'b1;
        step("lu_rs");
        ex_load = 1'b0;
        step("rs_no_load");

        // LU with coincident branch: flush deferred one cycle
        ex_load = 1'b1; id_branch_taken = 1'b1;
        #1;
        check("lu_br_flush", 32'(if_id_flush), 32'd0);
        check("lu_br_bubble", 32'(id_ex_bubble), 32'd1);
        step("lu_branch");
        ex_load = 1'b0;
        #1;
        check("br_flush_next", 32'(if_id_flush), 32'd1);
        step("branch_flush");
        id_branch_taken = 1'b0;
        id_use_rs = 1'b0;

        // memory wait of four low-ready cycles
        reset = 1'b0;
        step("rst_pre_mem");
        reset = 1'b1;
        mem_req = 1'b1;
        for (int i = 0; i < 4; i++) step("mem_wait_low");
        mem_ready = 1'b1;
        step("mem_ready");
        mem_req = 1'b0; mem_ready = 1'b0;
        step("mem_back_run");
        check("mem_stall_count", 32'(stall_count), 32'd4);
        check("mem_state_run", 32'(state), 32'd0);

        // reset in the middle of a wait
        mem_req = 1'b1;
        for (int i = 0; i < 3; i++) step("wait_pre_rst");
        reset = 1'b0;
        #1;
        check("rst_mid_bubble", 32'(id_ex_bubble), 32'd1);
        check("rst_mid_pc_we", 32'(pc_we), 32'd0);
        step("rst_mid_wait");
        reset = 1'b1; mem_req = 1'b0;
        check("rst_mid_state", 32'(state), 32'd0);
        check("rst_mid_stall", 32'(stall_count), 32'd0);
        step("after_rst_run");

        // timeout
        mem_req = 1'b1;
        for (int i = 0; i < 300; i++) step("timeout_run");
        check("timeout_flag", 32'(mem_timeout), 32'd1);
        check("timeout_state", 32'(state), 32'd2);
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) step("timeout_ready_ignored");
        reset = 1'b0;
        step("timeout_reset");
        reset = 1'b1; mem_req = 1'b0; mem_ready = 1'b0;
        check("timeout_cleared", 32'(mem_timeout), 32'd0);
        check("timeout_state_run", 32'(state), 32'd0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            reset           = ($urandom_range(0, 59) != 0);
            id_rn           = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 3));
            id_rm           = 4'($urandom_range(0, 3));
            id_rs           = 4'($urandom_range(0, 3));
            ex_reg_dst      = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 3));
            id_use_rn       = 1'($urandom_range(0, 1));
            id_use_rm       = 1'($urandom_range(0, 1));
            id_use_rs       = 1'($urandom_range(0, 1));
            ex_load         = 1'($urandom_range(0, 1));
            id_branch_taken = ($urandom_range(0, 3) == 0);
            mem_req         = ($urandom_range(0, 4) == 0);
            mem_ready       = ($urandom_range(0, 9) < 6);
            step("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
